// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the core load/store path and a DMA port.
// Core has priority; DMA is protected by a starvation bound and may burst under a bounded lock.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
    localparam logic [SCW-1:0] STARVE_ONE = SCW'(1);
    localparam logic [LCW-1:0] LOCK_TOP   = LCW'(LOCK_MAX);
    localparam logic [LCW-1:0] LOCK_ONE   = LCW'(1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e       state_q, state_d;
    logic [SCW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic              dma_win;
    logic              at_lock_max;

    always_comb begin
        at_lock_max = (lock_cnt_q == LOCK_TOP);
        dma_win     = ~rst & dma_req &
                      (~core_req | (starve_cnt_q == STARVE_TOP) |
                       ((state_q == LOCKED) & ~at_lock_max));

        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (dma_win) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
            mem_re    = ~dma_we;
        end else if (core_req && !rst) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
            mem_re    = ~core_we;
        end

        starve_cnt_d = starve_cnt_q;
        if (dma_win || !dma_req) begin
            starve_cnt_d = '0;
        end else if (core_req && starve_cnt_q != STARVE_TOP) begin
            starve_cnt_d = starve_cnt_q + STARVE_ONE;
        end

        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            UNLOCKED: begin
                if (dma_win && dma_lock) begin
                    state_d    = LOCKED;
                    lock_cnt_d = LOCK_ONE;
                end
            end
            LOCKED: begin
                if (!dma_req || (at_lock_max && core_req) || (dma_win && !dma_lock)) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else if (dma_win) begin
                    // At the cap with an idle core the burst simply restarts its count.
                    lock_cnt_d = at_lock_max ? LOCK_ONE : lock_cnt_q + LOCK_ONE;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                lock_cnt_d = '0;
            end
        endcase

        dma_rvalid_d = dma_win & ~dma_we;
        dma_rdata_d  = (dma_win && !dma_we) ? mem_rdata : dma_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign dma_gnt    = dma_win;
    assign core_stall = core_req & dma_win;
    assign core_rdata = mem_rdata;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for starvation, locked bursts and reset mid-burst.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dma_req, dma_we, dma_lock;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .LOCK_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe, dlock;
        logic [31:0] daddr, dwd, mrd;
        logic        e_gnt, e_stall, e_we, e_re;
        logic [31:0] e_addr, e_wdata;
        logic        chk_reg, e_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic creq, input logic cwe,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dreq, input logic dwe, input logic dlock,
                       input logic [31:0] daddr, input logic [31:0] dwd, input logic [31:0] mrd,
                       input logic gnt, input logic stall, input logic we, input logic re,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic chk_reg, input logic rv, input logic [31:0] rd);
        vec_t v;
        v.rst = r; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
        v.e_gnt = gnt; v.e_stall = stall; v.e_we = we; v.e_re = re;
        v.e_addr = addr; v.e_wdata = wdata; v.chk_reg = chk_reg; v.e_rvalid = rv; v.e_rdata = rd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic creq, input logic cwe,
                         input logic [31:0] caddr, input logic [31:0] cwd,
                         input logic dreq, input logic dwe, input logic dlock,
                         input logic [31:0] daddr, input logic [31:0] dwd, input logic [31:0] mrd);
        rst = r; core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_lock = dlock; dma_addr = daddr; dma_wdata = dwd;
        mem_rdata = mrd;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;

        // reset with both requesters active
        add(1, 1,1,32'h4,32'h11, 1,0,0,32'h80,32'hAA,0, 0,0,0,0,0,0, 0,0,0);
        add(1, 1,1,32'h4,32'h11, 1,0,0,32'h80,32'hAA,0, 0,0,0,0,0,0, 1,0,0);
        // continuous contention: DMA forced in on cycles 5 and 10
        for (int c = 1; c <= 10; c++) begin
            if (c == 5 || c == 10)
                add(0, 1,1,32'h4,32'h11, 1,1,0,32'h80,32'hAA,0, 1,1,1,0,32'h80,32'hAA, 1,0,0);
            else
                add(0, 1,1,32'h4,32'h11, 1,1,0,32'h80,32'hAA,0, 0,0,1,0,32'h4,32'h11, 1,0,0);
        end
        add(0, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0,0,0, 0,0,1,0,32'h10,32'hDEADBEEF, 1,0,0);
        add(0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0, 1,0,0);
        add(0, 0,0,0,0, 1,0,0,32'h20,0,32'h12345678, 1,0,0,1,32'h20,0, 1,0,0);
        add(0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0, 1,1,32'h12345678);
        add(0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0, 1,0,32'h12345678);
        // back-to-back reads give back-to-back pulses
        add(0, 0,0,0,0, 1,0,0,32'h30,0,32'hA1, 1,0,0,1,32'h30,0, 1,0,32'h12345678);
        add(0, 0,0,0,0, 1,0,0,32'h34,0,32'hA2, 1,0,0,1,32'h34,0, 1,1,32'hA1);
        add(0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0, 1,1,32'hA2);
        add(0, 0,0,0,0, 1,1,0,32'h40,32'h55,32'hEE, 1,0,1,0,32'h40,32'h55, 1,0,32'hA2);
        add(0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0, 1,0,32'hA2);
        add(0, 1,0,32'h8,32'h77, 0,0,0,0,0,32'h5, 0,0,0,1,32'h8,32'h77, 1,0,32'hA2);
        // a losing DMA read must not produce rvalid
        add(0, 1,0,32'h8,32'h77, 1,0,0,32'h50,0,32'h99, 0,0,0,1,32'h8,32'h77, 1,0,32'hA2);
        add(0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0, 1,0,32'hA2);

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].dlock, vecs[i].daddr, vecs[i].dwd, vecs[i].mrd);
            chk($sformatf("v%0d dma_gnt", i), {31'b0, dma_gnt}, {31'b0, vecs[i].e_gnt});
            chk($sformatf("v%0d core_stall", i), {31'b0, core_stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d mem_re", i), {31'b0, mem_re}, {31'b0, vecs[i].e_re});
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d core_rdata", i), core_rdata, vecs[i].mrd);
            if (vecs[i].chk_reg) begin
                chk($sformatf("v%0d dma_rvalid", i), {31'b0, dma_rvalid}, {31'b0, vecs[i].e_rvalid});
                chk($sformatf("v%0d dma_rdata", i), dma_rdata, vecs[i].e_rdata);
            end
            step();
        end

        // locked burst under continuous core traffic
        for (int c = 1; c <= 17; c++) begin
            logic exp_g;
            exp_g = ((c >= 5) && (c <= 12)) || (c == 17);
            drive(0, 1,1,32'h4,32'h11, 1,1,1,32'h90,32'hBB,0);
            chk($sformatf("lock c%0d dma_gnt", c), {31'b0, dma_gnt}, {31'b0, exp_g});
            chk($sformatf("lock c%0d core_stall", c), {31'b0, core_stall}, {31'b0, exp_g});
            chk($sformatf("lock c%0d mem_addr", c), mem_addr, exp_g ? 32'h90 : 32'h4);
            step();
        end
        drive(0, 0,0,0,0, 0,0,0,0,0,0);
        step();

        // idle core at the lock cap: lock restarts, so DMA still holds the core off later
        for (int c = 1; c <= 10; c++) begin
            drive(0, 0,0,0,0, 1,1,1,32'hA0,32'hCC,0);
            chk($sformatf("relock c%0d dma_gnt", c), {31'b0, dma_gnt}, 32'd1);
            step();
        end
        drive(0, 1,1,32'h4,32'h11, 1,1,1,32'hA0,32'hCC,0);
        chk("relock c11 core_stall", {31'b0, core_stall}, 32'd1);
        chk("relock c11 dma_gnt", {31'b0, dma_gnt}, 32'd1);
        step();
        drive(0, 0,0,0,0, 0,0,0,0,0,0);
        step();

        // reset in the middle of a locked read burst
        for (int c = 1; c <= 7; c++) begin
            drive(0, 0,0,0,0, 1,0,1,32'h200 + c,0,32'h100 + c);
            chk($sformatf("rburst c%0d dma_gnt", c), {31'b0, dma_gnt}, 32'd1);
            chk($sformatf("rburst c%0d dma_rvalid", c), {31'b0, dma_rvalid}, {31'b0, c > 1});
            if (c > 1)
                chk($sformatf("rburst c%0d dma_rdata", c), dma_rdata, 32'h100 + c - 1);
            step();
        end
        drive(1, 1,1,32'h4,32'h11, 1,0,1,32'h208,0,32'h108);
        chk("rst8 dma_gnt", {31'b0, dma_gnt}, 32'd0);
        chk("rst8 core_stall", {31'b0, core_stall}, 32'd0);
        chk("rst8 mem_re", {31'b0, mem_re}, 32'd0);
        chk("rst8 mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst8 dma_rvalid", {31'b0, dma_rvalid}, 32'd1);
        step();
        drive(0, 1,1,32'h4,32'h11, 1,0,1,32'h209,0,32'h109);
        chk("post_rst dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        chk("post_rst dma_rdata", dma_rdata, 32'd0);
        chk("post_rst dma_gnt", {31'b0, dma_gnt}, 32'd0);
        chk("post_rst core_stall", {31'b0, core_stall}, 32'd0);
        chk("post_rst mem_addr", mem_addr, 32'h4);
        step();
        drive(0, 0,0,0,0, 0,0,0,0,0,0);
        chk("post_rst2 dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the single-cycle core's load/store path and a DMA/loader port. It sits between the core's ALU-result/store-data path and DMEM. It drives the DMEM address, data and strobes from whichever requester wins the cycle. When the core loses, it raises `core_stall`; the top level gates `pc_write` and `reg_write` with it so the stalled instruction re-executes. Policy is core priority, with a starvation bound and a bounded DMA lock (burst) mode.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive core wins under contention before DMA is forced a grant (≥1)
- `LOCK_MAX`, 8, maximum consecutive locked DMA grants before a forced core cycle (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `core_req`  in  1  core needs DMEM this cycle (load or store)
- `core_we`  in  1  core store
- `core_addr`  in  ADDR_W  core address
- `core_wdata`  in  DATA_W  core store data
- `core_rdata`  out  DATA_W  `mem_rdata` passthrough; valid only when `core_stall`=0
- `core_stall`  out  1  core request not served this cycle
- `dma_req`  in  1  DMA needs DMEM
- `dma_we`  in  1  DMA write
- `dma_lock`  in  1  request to keep the grant on the next cycle (burst)
- `dma_addr`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  DMA owns DMEM this cycle (combinational)
- `dma_rdata`  out  DATA_W  registered read data
- `dma_rvalid`  out  1  one-cycle pulse, `dma_rdata` valid
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  to DMEM
- `mem_we`, `mem_re`  out  1  DMEM write/read strobes
- `mem_rdata`  in  DATA_W  DMEM combinational read data

## Operation
- State: `starve_cnt` (0..STARVE_MAX, saturating), `lock_cnt` (0..LOCK_MAX), `locked` flag, `dma_rdata`, `dma_rvalid`.
- Win rule (combinational), `dma_win = dma_req & (~core_req | starve_cnt==STARVE_MAX | (locked & lock_cnt<LOCK_MAX))`.
- `dma_gnt = dma_win`.
- `core_stall = core_req & dma_win`.
- Mux: when `dma_win`, drive `mem_*` from the `dma_*` inputs, with `mem_we=dma_we` and `mem_re=~dma_we`. Otherwise, when `core_req`, drive from the `core_*` inputs. Otherwise drive `mem_we`=`mem_re`=0, and address/data 0.
- `starve_cnt` update:
  - Increment when `dma_req & core_req & ~dma_win`.
  - Clear when `dma_win` or `~dma_req`.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED→LOCKED on a DMA grant with `dma_lock`=1; `lock_cnt`←1.
  - In LOCKED, each DMA grant with `dma_lock`=1 increments `lock_cnt`.
  - LOCKED→UNLOCKED when any of the following holds, with `lock_cnt`←0:
    - a grant occurs with `dma_lock`=0;
    - `dma_req`=0;
    - `lock_cnt`==LOCK_MAX and `core_req`=1, which forces a core cycle.
  - If `core_req`=0 at LOCK_MAX, DMA continues through the idle-core rule and the lock restarts at 1.
- DMA read return: on a DMA read grant, `dma_rdata`←`mem_rdata` at the edge, and `dma_rvalid`=1 for exactly the next cycle. Back-to-back reads give back-to-back pulses.
- A DMA write grant gives no rvalid.
- Core accesses are never registered here.

## Timing
- Grant and mux are zero-latency, in the same cycle as the request. A DMEM write commits at the edge closing the granted cycle.
- DMA read data latency is 1 cycle after the grant.
- The core is never stalled more than LOCK_MAX consecutive cycles. DMA under contention waits at most STARVE_MAX cycles.
- Simultaneous requests with `starve_cnt`<STARVE_MAX and no lock: core wins.
- Reset:
  - While `rst`=1, the combinational outputs are forced: `dma_gnt`=0, `core_stall`=0, `mem_we`=`mem_re`=0.
  - At the edge, `starve_cnt`=0, `lock_cnt`=0, state UNLOCKED, `dma_rdata`=0, `dma_rvalid`=0.
  - Reset mid-burst or with a read pending discards both; no rvalid follows reset.

## Test plan
- Reset: `rst`=1 for 2 cycles with both requests high → `dma_gnt`=0, `core_stall`=0, `mem_we`=0. After release, `dma_rvalid`=0 and the first contended cycle goes to the core.
- Core-only store to addr 0x10, data 0xDEADBEEF → `mem_we`=1, `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF, `core_stall`=0.
- Continuous contention, `dma_lock`=0, STARVE_MAX=4 → core wins cycles 1–4, DMA cycle 5, core 6–9, DMA 10. `core_stall`=1 only on cycles 5 and 10.
- DMA-only read of 0x20 with DMEM returning 0x12345678 → `dma_gnt`=1, `mem_re`=1. Next cycle `dma_rvalid`=1 with `dma_rdata`=0x12345678, then 0.
- Locked burst, `dma_lock`=1, LOCK_MAX=8, `core_req` continuous → DMA granted cycles 5–12, core forced on cycle 13, core 13–16, DMA next at cycle 17.
- `rst` asserted at cycle 8 of a locked read burst → `dma_rvalid`=0 the cycle after, lock cleared. After release, the core is granted first under contention.
